// File: rtl/vga_timing_gen.sv
// ============================================================================
// vga_timing_gen
// ----------------------------------------------------------------------------
// Parametrised VGA timing generator and pixel pipeline.
//
// Each line and each frame is laid out as front porch, sync, back porch and
// then active video. During active video the block issues a pixel fetch
// request carrying the (optionally down-scaled) pixel coordinates and a
// linear frame-buffer address. The host returns the colour PIX_LAT cycles
// later. Sync and blank are delayed through a matching register pipe, so the
// DAC sees HS/VS/BLANK change on the same edge as the colour they belong to.
//
// Ports
//   iCLK              in   1       pixel clock
//   iRST_N            in   1       synchronous active-low reset
//   iEnable           in   1       run timing; low holds the block idle
//   iRed/iGreen/iBlue in   CW      host colour, valid PIX_LAT cycles after oRequest
//   oRequest          out  1       active-pixel fetch request
//   oCurrent_X        out  CNT_W   scaled X of the requested pixel
//   oCurrent_Y        out  CNT_W   scaled Y of the requested pixel
//   oAddress          out  ADDR_W  oCurrent_Y*(H_ACT>>SCALE_SHIFT)+oCurrent_X
//   oVGA_R/G/B        out  CW      registered colour to the DAC
//   oVGA_HS           out  1       registered, aligned horizontal sync
//   oVGA_VS           out  1       registered, aligned vertical sync
//   oVGA_BLANK        out  1       1 = active video, 0 = blanked
//   oVGA_SYNC         out  1       tied low
//   oVGA_CLOCK        out  1       copy of iCLK
//   oFrame_Start      out  1       one-cycle pulse at H=0, V=0 (counter timing)
//   oActive_Start     out  1       one-cycle pulse at first active pixel of frame
// ============================================================================
module vga_timing_gen #(
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int H_ACT       = 640,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int V_ACT       = 480,
    parameter int HS_POL      = 0,
    parameter int VS_POL      = 0,
    parameter int CW          = 8,
    parameter int CNT_W       = 11,
    parameter int ADDR_W      = 22,
    parameter int PIX_LAT     = 2,
    parameter int SCALE_SHIFT = 0
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              iEnable,
    input  logic [CW-1:0]     iRed,
    input  logic [CW-1:0]     iGreen,
    input  logic [CW-1:0]     iBlue,
    output logic              oRequest,
    output logic [CNT_W-1:0]  oCurrent_X,
    output logic [CNT_W-1:0]  oCurrent_Y,
    output logic [ADDR_W-1:0] oAddress,
    output logic [CW-1:0]     oVGA_R,
    output logic [CW-1:0]     oVGA_G,
    output logic [CW-1:0]     oVGA_B,
    output logic              oVGA_HS,
    output logic              oVGA_VS,
    output logic              oVGA_BLANK,
    output logic              oVGA_SYNC,
    output logic              oVGA_CLOCK,
    output logic              oFrame_Start,
    output logic              oActive_Start
);

    // ------------------------------------------------------------------
    // Derived timing constants
    // ------------------------------------------------------------------
    localparam int H_TOTAL = H_FRONT + H_SYNC + H_BACK + H_ACT;
    localparam int V_TOTAL = V_FRONT + V_SYNC + V_BACK + V_ACT;
    localparam int H_BLANK = H_FRONT + H_SYNC + H_BACK;
    localparam int V_BLANK = V_FRONT + V_SYNC + V_BACK;
    localparam int PW      = PIX_LAT + 1;

    localparam logic [CNT_W-1:0] CNT_ZERO_C = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE_C  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] H_LAST_C   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST_C   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_BLANK_C  = CNT_W'(H_BLANK);
    localparam logic [CNT_W-1:0] V_BLANK_C  = CNT_W'(V_BLANK);
    localparam logic [CNT_W-1:0] HS_FIRST_C = CNT_W'(H_FRONT);
    localparam logic [CNT_W-1:0] HS_LAST_C  = CNT_W'(H_FRONT + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST_C = CNT_W'(V_FRONT);
    localparam logic [CNT_W-1:0] VS_LAST_C  = CNT_W'(V_FRONT + V_SYNC - 1);

    // Words per stored line: a scaled frame stores H_ACT>>SCALE_SHIFT pixels per row.
    localparam logic [ADDR_W-1:0] LINE_WORDS_C = ADDR_W'(H_ACT >> SCALE_SHIFT);

    localparam logic HS_ACT_C  = (HS_POL != 0) ? 1'b1 : 1'b0;
    localparam logic VS_ACT_C  = (VS_POL != 0) ? 1'b1 : 1'b0;
    localparam logic HS_IDLE_C = ~HS_ACT_C;
    localparam logic VS_IDLE_C = ~VS_ACT_C;

    localparam logic [CW-1:0] CW_ZERO_C = {CW{1'b0}};

    // Inclusive range test used by the sync decoders.
    function automatic logic inRange(input logic [CNT_W-1:0] value,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
        return (value >= lo) && (value <= hi);
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic              running_r;   // counters have been released this run
    logic [CNT_W-1:0]  hCont_r;
    logic [CNT_W-1:0]  vCont_r;
    logic [PIX_LAT:0]  hsPipe_r;
    logic [PIX_LAT:0]  vsPipe_r;
    logic [PIX_LAT:0]  actPipe_r;
    logic [CW-1:0]     red_r;
    logic [CW-1:0]     green_r;
    logic [CW-1:0]     blue_r;

    logic              idle_s;
    logic              act_s;
    logic              hsRaw_s;
    logic              vsRaw_s;
    logic [CNT_W-1:0]  rawX_s;
    logic [CNT_W-1:0]  rawY_s;
    logic [CNT_W-1:0]  curX_s;
    logic [CNT_W-1:0]  curY_s;
    logic [ADDR_W-1:0] addr_s;
    logic              frameStart_s;
    logic              activeStart_s;
    logic [PIX_LAT:0]  hsChain_s;
    logic [PIX_LAT:0]  vsChain_s;
    logic [PIX_LAT:0]  actChain_s;

    // Reset and disable share one idle path.
    assign idle_s = !iRST_N || !iEnable;

    // Run flag: the first cycle after leaving idle holds H=V=0 so it can be
    // marked by oFrame_Start before the counters start moving.
    always_ff @(posedge iCLK) begin
        if (idle_s) begin
            running_r <= 1'b0;
        end else begin
            running_r <= 1'b1;
        end
    end

    // Horizontal and vertical counters; V advances on the last pixel of a line.
    always_ff @(posedge iCLK) begin
        if (idle_s || !running_r) begin
            hCont_r <= CNT_ZERO_C;
            vCont_r <= CNT_ZERO_C;
        end else if (hCont_r == H_LAST_C) begin
            hCont_r <= CNT_ZERO_C;
            if (vCont_r == V_LAST_C) begin
                vCont_r <= CNT_ZERO_C;
            end else begin
                vCont_r <= vCont_r + CNT_ONE_C;
            end
        end else begin
            hCont_r <= hCont_r + CNT_ONE_C;
            vCont_r <= vCont_r;
        end
    end

    // Counter-domain decode: active window, raw sync, coordinates and address.
    always_comb begin
        act_s   = running_r && (hCont_r >= H_BLANK_C) && (vCont_r >= V_BLANK_C);
        hsRaw_s = running_r && inRange(hCont_r, HS_FIRST_C, HS_LAST_C);
        vsRaw_s = running_r && inRange(vCont_r, VS_FIRST_C, VS_LAST_C);
        rawX_s  = hCont_r - H_BLANK_C;
        rawY_s  = vCont_r - V_BLANK_C;
        if (act_s) begin
            curX_s = rawX_s >> SCALE_SHIFT;
            curY_s = rawY_s >> SCALE_SHIFT;
        end else begin
            curX_s = CNT_ZERO_C;
            curY_s = CNT_ZERO_C;
        end
        addr_s = (ADDR_W'(curY_s) * LINE_WORDS_C) + ADDR_W'(curX_s);
    end

    // Frame markers, only while running so an idle block never pulses.
    always_comb begin
        frameStart_s  = running_r && (hCont_r == CNT_ZERO_C) && (vCont_r == CNT_ZERO_C);
        activeStart_s = running_r && (hCont_r == H_BLANK_C) && (vCont_r == V_BLANK_C);
    end

    // Next values of each delay stage: stage 0 takes the decode, stage i the
    // previous stage. Bit PIX_LAT is what the output stage loads next.
    always_comb begin
        hsChain_s     = {PW{1'b0}};
        vsChain_s     = {PW{1'b0}};
        actChain_s    = {PW{1'b0}};
        hsChain_s[0]  = hsRaw_s ? HS_ACT_C : HS_IDLE_C;
        vsChain_s[0]  = vsRaw_s ? VS_ACT_C : VS_IDLE_C;
        actChain_s[0] = act_s;
        for (int i = 1; i <= PIX_LAT; i++) begin
            hsChain_s[i]  = hsPipe_r[i-1];
            vsChain_s[i]  = vsPipe_r[i-1];
            actChain_s[i] = actPipe_r[i-1];
        end
    end

    // Sync/blank delay pipe, PIX_LAT+1 deep so it lines up with returned colour.
    always_ff @(posedge iCLK) begin
        if (idle_s) begin
            hsPipe_r  <= {PW{HS_IDLE_C}};
            vsPipe_r  <= {PW{VS_IDLE_C}};
            actPipe_r <= {PW{1'b0}};
        end else begin
            hsPipe_r  <= hsChain_s;
            vsPipe_r  <= vsChain_s;
            actPipe_r <= actChain_s;
        end
    end

    // Colour register: host data is captured only when the pixel it belongs
    // to is active once it reaches the output, otherwise black.
    always_ff @(posedge iCLK) begin
        if (idle_s) begin
            red_r   <= CW_ZERO_C;
            green_r <= CW_ZERO_C;
            blue_r  <= CW_ZERO_C;
        end else if (actChain_s[PIX_LAT]) begin
            red_r   <= iRed;
            green_r <= iGreen;
            blue_r  <= iBlue;
        end else begin
            red_r   <= CW_ZERO_C;
            green_r <= CW_ZERO_C;
            blue_r  <= CW_ZERO_C;
        end
    end

    assign oRequest      = act_s;
    assign oCurrent_X    = curX_s;
    assign oCurrent_Y    = curY_s;
    assign oAddress      = addr_s;
    assign oFrame_Start  = frameStart_s;
    assign oActive_Start = activeStart_s;

    assign oVGA_R        = red_r;
    assign oVGA_G        = green_r;
    assign oVGA_B        = blue_r;
    assign oVGA_HS       = hsPipe_r[PIX_LAT];
    assign oVGA_VS       = vsPipe_r[PIX_LAT];
    assign oVGA_BLANK    = actPipe_r[PIX_LAT];
    assign oVGA_SYNC     = 1'b0;
    assign oVGA_CLOCK    = iCLK;

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

    logic iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    int checks = 0;
    int errors = 0;

    // ---------------- default-parameter DUT and scaled DUT (shared control)
    logic        rstN, en;
    logic [7:0]  red, green, blue;
    logic        req, hs, vs, blank, syncO, clkO, fs, as_;
    logic [10:0] curX, curY;
    logic [21:0] addr;
    logic [7:0]  vgaR, vgaG, vgaB;

    logic        reqS, hsS, vsS, blankS, syncS, clkS, fsS, asS;
    logic [10:0] curXS, curYS;
    logic [21:0] addrS;
    logic [7:0]  vgaRS, vgaGS, vgaBS;

    // ---------------- small-timing DUT, HS active high, PIX_LAT=1
    logic        rstP, enP;
    logic        reqP, hsP, vsP, blankP, syncP, clkP, fsP, asP;
    logic [10:0] curXP, curYP;
    logic [21:0] addrP;
    logic [7:0]  vgaRP, vgaGP, vgaBP;

    vga_timing_gen dut (
        .iCLK(iCLK), .iRST_N(rstN), .iEnable(en),
        .iRed(red), .iGreen(green), .iBlue(blue),
        .oRequest(req), .oCurrent_X(curX), .oCurrent_Y(curY), .oAddress(addr),
        .oVGA_R(vgaR), .oVGA_G(vgaG), .oVGA_B(vgaB),
        .oVGA_HS(hs), .oVGA_VS(vs), .oVGA_BLANK(blank), .oVGA_SYNC(syncO),
        .oVGA_CLOCK(clkO), .oFrame_Start(fs), .oActive_Start(as_)
    );

    vga_timing_gen #(.SCALE_SHIFT(1)) dutS (
        .iCLK(iCLK), .iRST_N(rstN), .iEnable(en),
        .iRed(8'h00), .iGreen(8'h00), .iBlue(8'h00),
        .oRequest(reqS), .oCurrent_X(curXS), .oCurrent_Y(curYS), .oAddress(addrS),
        .oVGA_R(vgaRS), .oVGA_G(vgaGS), .oVGA_B(vgaBS),
        .oVGA_HS(hsS), .oVGA_VS(vsS), .oVGA_BLANK(blankS), .oVGA_SYNC(syncS),
        .oVGA_CLOCK(clkS), .oFrame_Start(fsS), .oActive_Start(asS)
    );

    vga_timing_gen #(
        .H_FRONT(2), .H_SYNC(3), .H_BACK(4), .H_ACT(8),
        .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .V_ACT(4),
        .HS_POL(1), .PIX_LAT(1)
    ) dutP (
        .iCLK(iCLK), .iRST_N(rstP), .iEnable(enP),
        .iRed(8'h00), .iGreen(8'h00), .iBlue(8'h00),
        .oRequest(reqP), .oCurrent_X(curXP), .oCurrent_Y(curYP), .oAddress(addrP),
        .oVGA_R(vgaRP), .oVGA_G(vgaGP), .oVGA_B(vgaBP),
        .oVGA_HS(hsP), .oVGA_VS(vsP), .oVGA_BLANK(blankP), .oVGA_SYNC(syncP),
        .oVGA_CLOCK(clkP), .oFrame_Start(fsP), .oActive_Start(asP)
    );

    // Host model: returns red = requested x[7:0] two cycles after the request.
    logic [10:0] xd1, xd2;
    always @(posedge iCLK) begin
        xd1 <= curX;
        xd2 <= xd1;
    end
    assign red   = xd2[7:0];
    assign green = 8'h55;
    assign blue  = 8'hAA;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick;
        @(negedge iCLK);
    endtask

    // Bounded wait for a frame-start pulse; sel=1 watches the small DUT.
    task automatic waitFs(input string name, input bit sel, input int budget, output int cycles);
        bit found = 1'b0;
        cycles = 0;
        while (!found && cycles < budget) begin
            tick();
            cycles++;
            if ((sel ? fsP : fs) === 1'b1) found = 1'b1;
        end
        chk({name, "_seen"}, 32'(found), 32'd1);
    endtask

    typedef struct {
        int          k;
        logic        req, fs, as_;
        logic [10:0] x, y;
        logic [21:0] addr;
        logic        hs, vs, blank;
        logic [7:0]  r, g;
        logic [10:0] sx, sy;
        logic [21:0] saddr;
    } vec_t;

    function automatic vec_t mk(int k, int rq, int f, int a, int x, int y, int ad,
                                int h, int v, int b, int r, int g, int sx, int sy, int sa);
        vec_t t;
        t.k = k; t.req = rq[0]; t.fs = f[0]; t.as_ = a[0];
        t.x = 11'(x); t.y = 11'(y); t.addr = 22'(ad);
        t.hs = h[0]; t.vs = v[0]; t.blank = b[0];
        t.r = 8'(r); t.g = 8'(g);
        t.sx = 11'(sx); t.sy = 11'(sy); t.saddr = 22'(sa);
        return t;
    endfunction

    vec_t vec [24];

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int cyc;
        int k;
        int hsHigh, vsLow, blankHigh, fsCnt, asCnt, asFirst, asSecond, vsFall;

        // k = cycles since oFrame_Start; outputs trail counters by 3 cycles.
        //         k      rq fs as x   y  addr  hs vs bl r     g     sx  sy sa
        vec[0]  = mk(0,     0, 1, 0, 0,  0, 0,    1, 1, 0, 0,    0,    0,  0, 0);
        vec[1]  = mk(1,     0, 0, 0, 0,  0, 0,    1, 1, 0, 0,    0,    0,  0, 0);
        vec[2]  = mk(18,    0, 0, 0, 0,  0, 0,    1, 1, 0, 0,    0,    0,  0, 0);
        vec[3]  = mk(19,    0, 0, 0, 0,  0, 0,    0, 1, 0, 0,    0,    0,  0, 0);
        vec[4]  = mk(114,   0, 0, 0, 0,  0, 0,    0, 1, 0, 0,    0,    0,  0, 0);
        vec[5]  = mk(115,   0, 0, 0, 0,  0, 0,    1, 1, 0, 0,    0,    0,  0, 0);
        vec[6]  = mk(818,   0, 0, 0, 0,  0, 0,    1, 1, 0, 0,    0,    0,  0, 0);
        vec[7]  = mk(819,   0, 0, 0, 0,  0, 0,    0, 1, 0, 0,    0,    0,  0, 0);
        vec[8]  = mk(8002,  0, 0, 0, 0,  0, 0,    1, 1, 0, 0,    0,    0,  0, 0);
        vec[9]  = mk(8003,  0, 0, 0, 0,  0, 0,    1, 0, 0, 0,    0,    0,  0, 0);
        vec[10] = mk(9602,  0, 0, 0, 0,  0, 0,    1, 0, 0, 0,    0,    0,  0, 0);
        vec[11] = mk(9603,  0, 0, 0, 0,  0, 0,    1, 1, 0, 0,    0,    0,  0, 0);
        vec[12] = mk(36159, 0, 0, 0, 0,  0, 0,    1, 1, 0, 0,    0,    0,  0, 0);
        vec[13] = mk(36160, 1, 0, 1, 0,  0, 0,    1, 1, 0, 0,    0,    0,  0, 0);
        vec[14] = mk(36161, 1, 0, 0, 1,  0, 1,    1, 1, 0, 0,    0,    0,  0, 0);
        vec[15] = mk(36162, 1, 0, 0, 2,  0, 2,    1, 1, 0, 0,    0,    1,  0, 1);
        vec[16] = mk(36163, 1, 0, 0, 3,  0, 3,    1, 1, 1, 'h00, 'h55, 1,  0, 1);
        vec[17] = mk(36164, 1, 0, 0, 4,  0, 4,    1, 1, 1, 'h01, 'h55, 2,  0, 2);
        vec[18] = mk(36799, 1, 0, 0, 639,0, 639,  1, 1, 1, 'h7C, 'h55, 319,0, 319);
        vec[19] = mk(36802, 0, 0, 0, 0,  0, 0,    1, 1, 1, 'h7F, 'h55, 0,  0, 0);
        vec[20] = mk(36803, 0, 0, 0, 0,  0, 0,    1, 1, 0, 0,    0,    0,  0, 0);
        vec[21] = mk(36965, 1, 0, 0, 5,  1, 645,  1, 1, 1, 'h02, 'h55, 2,  0, 2);
        vec[22] = mk(37765, 1, 0, 0, 5,  2, 1285, 1, 1, 1, 'h02, 'h55, 2,  1, 322);
        vec[23] = mk(38565, 1, 0, 0, 5,  3, 1925, 1, 1, 1, 'h02, 'h55, 2,  1, 322);

        rstN = 1'b0; en = 1'b1; rstP = 1'b0; enP = 1'b1;
        repeat (3) tick();
        chk("reset_hs", 32'(hs), 32'd1);
        chk("reset_vs", 32'(vs), 32'd1);
        chk("reset_blank", 32'(blank), 32'd0);
        chk("reset_fs", 32'(fs), 32'd0);
        chk("reset_sync_tied", 32'(syncO), 32'd0);
        chk("pol_hs_idle", 32'(hsP), 32'd0);

        // First release, then run into the HS pulse and reset mid-line.
        rstN = 1'b1;
        waitFs("fs_first", 1'b0, 20, cyc);
        chk("fs_first_latency", 32'(cyc), 32'd1);
        repeat (100) tick();
        chk("hs_low_before_reset", 32'(hs), 32'd0);
        rstN = 1'b0;
        tick();
        chk("rst_hs", 32'(hs), 32'd1);
        chk("rst_vs", 32'(vs), 32'd1);
        chk("rst_blank", 32'(blank), 32'd0);
        chk("rst_r", 32'(vgaR), 32'd0);
        chk("rst_req", 32'(req), 32'd0);
        repeat (4) tick();
        chk("rst_fs_quiet", 32'(fs), 32'd0);
        rstN = 1'b1;
        waitFs("fs_after_reset", 1'b0, 20, cyc);
        chk("fs_after_reset_latency", 32'(cyc), 32'd1);

        // Table-driven walk through the first 49 lines.
        k = 0;
        for (int i = 0; i < 24; i++) begin
            while (k < vec[i].k) begin
                tick();
                k++;
            end
            chk($sformatf("v%0d_req", i),   32'(req),   32'(vec[i].req));
            chk($sformatf("v%0d_fs", i),    32'(fs),    32'(vec[i].fs));
            chk($sformatf("v%0d_as", i),    32'(as_),   32'(vec[i].as_));
            chk($sformatf("v%0d_x", i),     32'(curX),  32'(vec[i].x));
            chk($sformatf("v%0d_y", i),     32'(curY),  32'(vec[i].y));
            chk($sformatf("v%0d_addr", i),  32'(addr),  32'(vec[i].addr));
            chk($sformatf("v%0d_hs", i),    32'(hs),    32'(vec[i].hs));
            chk($sformatf("v%0d_vs", i),    32'(vs),    32'(vec[i].vs));
            chk($sformatf("v%0d_blank", i), 32'(blank), 32'(vec[i].blank));
            chk($sformatf("v%0d_r", i),     32'(vgaR),  32'(vec[i].r));
            chk($sformatf("v%0d_g", i),     32'(vgaG),  32'(vec[i].g));
            chk($sformatf("v%0d_sx", i),    32'(curXS), 32'(vec[i].sx));
            chk($sformatf("v%0d_sy", i),    32'(curYS), 32'(vec[i].sy));
            chk($sformatf("v%0d_saddr", i), 32'(addrS), 32'(vec[i].saddr));
        end

        // Enable dropped mid-active-line, then restart.
        en = 1'b0;
        tick();
        chk("dis_req", 32'(req), 32'd0);
        chk("dis_x", 32'(curX), 32'd0);
        chk("dis_hs", 32'(hs), 32'd1);
        chk("dis_vs", 32'(vs), 32'd1);
        chk("dis_blank", 32'(blank), 32'd0);
        chk("dis_r", 32'(vgaR), 32'd0);
        repeat (3) tick();
        chk("dis_fs_quiet", 32'(fs), 32'd0);
        en = 1'b1;
        waitFs("fs_reenable", 1'b0, 20, cyc);
        chk("fs_reenable_latency", 32'(cyc), 32'd1);
        tick();
        chk("fs_single_pulse", 32'(fs), 32'd0);
        repeat (17) tick();
        chk("reen_hs_18", 32'(hs), 32'd1);
        tick();
        chk("reen_hs_19", 32'(hs), 32'd0);

        // Small-timing DUT: two whole frames of counting.
        rstP = 1'b1;
        waitFs("fsP", 1'b1, 20, cyc);
        hsHigh = 0; vsLow = 0; blankHigh = 0; fsCnt = 0; asCnt = 0;
        asFirst = -1; asSecond = -1; vsFall = -1;
        for (int j = 0; j < 308; j++) begin
            if (j > 0) tick();
            if (j >= 2) begin
                if (hsP) hsHigh++;
                if (!vsP) vsLow++;
                if (blankP) blankHigh++;
            end
            if (!vsP && vsFall < 0) vsFall = j;
            if (j < 306) begin
                if (fsP) fsCnt++;
                if (asP) begin
                    if (asCnt == 0) asFirst = j;
                    else if (asCnt == 1) asSecond = j;
                    asCnt++;
                end
            end
        end
        chk("p_fs_count", 32'(fsCnt), 32'd2);
        chk("p_as_count", 32'(asCnt), 32'd2);
        chk("p_as_first", 32'(asFirst), 32'd94);
        chk("p_as_second", 32'(asSecond), 32'd247);
        chk("p_hs_high", 32'(hsHigh), 32'd54);
        chk("p_vs_low", 32'(vsLow), 32'd68);
        chk("p_blank_high", 32'(blankHigh), 32'd64);
        chk("p_vs_first_fall", 32'(vsFall), 32'd19);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
